// File: rtl/cache_way_flush_p.sv
// One way of the pipelined cache: valid/dirty/tag/data arrays with a registered, write-forwarded
// lookup, plus a flush engine that sweeps every set and offers dirty lines to writeback.
module cache_way_flush_p #(
  parameter int S_INDEX    = 3,
  parameter int TAG_W      = 24,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_INDEX-1:0]      rindex_i,
  input  logic [S_INDEX-1:0]      windex_i,
  input  logic                    load_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [8*LINE_BYTES-1:0] data_i,
  input  logic [LINE_BYTES-1:0]   byte_enable_i,
  input  logic                    set_dirty_i,
  input  logic                    clr_dirty_i,
  input  logic                    flush_req_i,
  input  logic                    flush_inv_i,
  output logic [TAG_W-1:0]        tag_o,
  output logic                    valid_o,
  output logic                    dirty_o,
  output logic [8*LINE_BYTES-1:0] data_o,
  output logic                    busy_o,
  output logic                    flush_done_o,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [S_INDEX-1:0]      wb_index_o,
  output logic [TAG_W-1:0]        wb_tag_o,
  output logic [8*LINE_BYTES-1:0] wb_data_o
);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int NSETS  = 2 ** S_INDEX;

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

  state_t               state_q, state_d;
  logic [S_INDEX-1:0]   ptr_q, ptr_d;
  logic                 inv_q;

  logic [NSETS-1:0]     valid_q;
  logic [NSETS-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [NSETS];
  logic [LINE_W-1:0]    data_q [NSETS];

  logic                 wr_en;
  logic                 clr_v_en;
  logic                 clr_d_en;

  logic                 lk_valid, lk_dirty;
  logic [TAG_W-1:0]     lk_tag;
  logic [LINE_W-1:0]    lk_data;

  function automatic logic [LINE_W-1:0] merge_bytes(input logic [LINE_W-1:0]     old_line,
                                                    input logic [LINE_W-1:0]     new_line,
                                                    input logic [LINE_BYTES-1:0] be);
    logic [LINE_W-1:0] res;
    res = old_line;
    for (int b = 0; b < LINE_BYTES; b++)
      if (be[b]) res[8*b +: 8] = new_line[8*b +: 8];
    return res;
  endfunction

  assign wr_en        = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign flush_done_o = (state_q == DONE);
  assign wb_valid_o   = (state_q == WB);
  assign wb_index_o   = wb_valid_o ? ptr_q : '0;
  assign wb_tag_o     = wb_valid_o ? tag_q[ptr_q] : '0;
  assign wb_data_o    = wb_valid_o ? data_q[ptr_q] : '0;

  // Flush FSM: next state, pointer advance and the clears it drives into the arrays
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_v_en = 1'b0;
    clr_d_en = 1'b0;
    case (state_q)
      IDLE: if (flush_req_i) begin
        state_d = SCAN;
        ptr_d   = '0;
      end
      SCAN: begin
        if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
          state_d = WB;
        end else begin
          clr_v_en = inv_q;
          if (ptr_q == '1) state_d = DONE;
          else             ptr_d   = ptr_q + 1'b1;
        end
      end
      WB: if (wb_ready_i) begin
        clr_d_en = 1'b1;
        clr_v_en = inv_q;
        if (ptr_q == '1) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
          ptr_d   = ptr_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == IDLE && flush_req_i) inv_q <= flush_inv_i;
    end
  end

  // Array update: external writes only when idle, flush clears only when busy, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NSETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        if (load_i) begin
          valid_q[windex_i] <= 1'b1;
          tag_q[windex_i]   <= tag_i;
        end
        data_q[windex_i] <= merge_bytes(data_q[windex_i], data_i, byte_enable_i);
        if (set_dirty_i)      dirty_q[windex_i] <= 1'b1;
        else if (clr_dirty_i) dirty_q[windex_i] <= 1'b0;
      end
      if (clr_v_en) valid_q[ptr_q] <= 1'b0;
      if (clr_d_en) dirty_q[ptr_q] <= 1'b0;
    end
  end

  // Lookup forwarding: present the post-write state of the looked-up set
  always_comb begin
    lk_valid = valid_q[rindex_i];
    lk_dirty = dirty_q[rindex_i];
    lk_tag   = tag_q[rindex_i];
    lk_data  = data_q[rindex_i];
    if (wr_en && windex_i == rindex_i) begin
      if (load_i) begin
        lk_valid = 1'b1;
        lk_tag   = tag_i;
      end
      lk_data = merge_bytes(data_q[rindex_i], data_i, byte_enable_i);
      if (set_dirty_i)      lk_dirty = 1'b1;
      else if (clr_dirty_i) lk_dirty = 1'b0;
    end
    if (clr_v_en && ptr_q == rindex_i) lk_valid = 1'b0;
    if (clr_d_en && ptr_q == rindex_i) lk_dirty = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      dirty_o <= 1'b0;
      tag_o   <= '0;
      data_o  <= '0;
    end else begin
      valid_o <= lk_valid;
      dirty_o <= lk_dirty;
      tag_o   <= lk_tag;
      data_o  <= lk_data;
    end
  end
endmodule

// File: tb/tb_cache_way_flush_p.sv
// Scoreboard bench for cache_way_flush_p: lookups and writebacks queue expected results,
// monitors pop and compare when the DUT presents them.
module tb_cache_way_flush_p;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   rindex_i, windex_i;
  logic         load_i;
  logic [23:0]  tag_i;
  logic [255:0] data_i;
  logic [31:0]  byte_enable_i;
  logic         set_dirty_i, clr_dirty_i;
  logic         flush_req_i, flush_inv_i;
  logic [23:0]  tag_o;
  logic         valid_o, dirty_o;
  logic [255:0] data_o;
  logic         busy_o, flush_done_o;
  logic         wb_valid_o, wb_ready_i;
  logic [2:0]   wb_index_o;
  logic [23:0]  wb_tag_o;
  logic [255:0] wb_data_o;

  cache_way_flush_p dut (
    .clk(clk), .rst(rst), .rindex_i(rindex_i), .windex_i(windex_i), .load_i(load_i),
    .tag_i(tag_i), .data_i(data_i), .byte_enable_i(byte_enable_i), .set_dirty_i(set_dirty_i),
    .clr_dirty_i(clr_dirty_i), .flush_req_i(flush_req_i), .flush_inv_i(flush_inv_i),
    .tag_o(tag_o), .valid_o(valid_o), .dirty_o(dirty_o), .data_o(data_o), .busy_o(busy_o),
    .flush_done_o(flush_done_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_index_o(wb_index_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic v; logic d; logic [23:0] tag; logic [255:0] data; } lk_exp_t;
  typedef struct packed { logic [2:0] idx; logic [23:0] tag; logic [255:0] data; } wb_exp_t;

  lk_exp_t lk_q[$];
  wb_exp_t wb_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      done_cnt = 0;
  logic    lk_req = 1'b0;
  logic    lk_pend = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Lookup monitor: a lookup issued in one cycle is presented after the next edge
  always @(posedge clk) lk_pend <= lk_req;

  always @(negedge clk) begin
    if (lk_pend) begin
      if (lk_q.size() == 0) begin
        check("lk_queue_empty", 256'(1), 256'(0));
      end else begin
        lk_exp_t e;
        e = lk_q.pop_front();
        check("lk_valid", 256'(valid_o), 256'(e.v));
        check("lk_dirty", 256'(dirty_o), 256'(e.d));
        check("lk_tag",   256'(tag_o),   256'(e.tag));
        check("lk_data",  data_o,        e.data);
      end
    end
    if (wb_valid_o && wb_ready_i) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", 256'(1), 256'(0));
      end else begin
        wb_exp_t w;
        w = wb_q.pop_front();
        check("wb_index", 256'(wb_index_o), 256'(w.idx));
        check("wb_tag",   256'(wb_tag_o),   256'(w.tag));
        check("wb_data",  wb_data_o,        w.data);
      end
    end
    if (flush_done_o) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    load_i = 1'b0; byte_enable_i = '0; set_dirty_i = 1'b0; clr_dirty_i = 1'b0;
    flush_req_i = 1'b0; lk_req = 1'b0;
  endtask

  task automatic set_wr(input logic [2:0] idx, input logic ld, input logic [23:0] t,
                        input logic [255:0] d, input logic [31:0] be, input logic sd, input logic cd);
    windex_i = idx; load_i = ld; tag_i = t; data_i = d; byte_enable_i = be;
    set_dirty_i = sd; clr_dirty_i = cd;
  endtask

  task automatic set_lk(input logic [2:0] idx, input logic v, input logic d,
                        input logic [23:0] t, input logic [255:0] dat);
    rindex_i = idx; lk_req = 1'b1;
    lk_q.push_back('{v: v, d: d, tag: t, data: dat});
  endtask

  task automatic wait_wb(input string nm);
    int n;
    n = 0;
    while (!wb_valid_o && n < 20) begin tick(); n++; end
    check(nm, 256'(wb_valid_o), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_snap;
    rst = 1'b1; rindex_i = '0; windex_i = '0; load_i = 1'b0; tag_i = '0; data_i = '0;
    byte_enable_i = '0; set_dirty_i = 1'b0; clr_dirty_i = 1'b0; flush_req_i = 1'b0;
    flush_inv_i = 1'b0; wb_ready_i = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;

    // Post-reset state
    check("rst_busy",  256'(busy_o),     256'(0));
    check("rst_wbvld", 256'(wb_valid_o), 256'(0));
    check("rst_tag",   256'(tag_o),      256'(0));
    set_lk(3'd0, 0, 0, 24'h0, 256'h0); tick();
    set_lk(3'd7, 0, 0, 24'h0, 256'h0); tick();

    // Load set 5 with the low four bytes enabled
    set_wr(3'd5, 1, 24'hABCDEF, {32{8'h11}}, 32'h0000000F, 0, 0); tick();
    set_lk(3'd5, 1, 0, 24'hABCDEF, 256'h11111111); tick();

    // Same-cycle write and lookup on set 2, then a second merge
    set_wr(3'd2, 1, 24'h000222, {32{8'h22}}, 32'h000000F0, 1, 0);
    set_lk(3'd2, 1, 1, 24'h000222, 256'h22222222_00000000); tick();
    set_wr(3'd2, 0, 24'h0, {32{8'h33}}, 32'h00000003, 0, 0);
    set_lk(3'd2, 1, 1, 24'h000222, 256'h22222222_00003333); tick();
    set_wr(3'd2, 0, 24'h0, {32{8'h44}}, 32'h0, 1, 1);
    set_lk(3'd2, 1, 1, 24'h000222, 256'h22222222_00003333); tick();
    set_wr(3'd2, 0, 24'h0, {32{8'h55}}, 32'h0, 0, 1);
    set_lk(3'd2, 1, 0, 24'h000222, 256'h22222222_00003333); tick();

    // Flush with two dirty sets and writeback backpressure
    set_wr(3'd1, 1, 24'h111111, {32{8'hA1}}, 32'hFFFFFFFF, 1, 0); tick();
    set_wr(3'd6, 1, 24'h666666, {32{8'hB6}}, 32'hFFFFFFFF, 1, 0); tick();
    wb_q.push_back('{idx: 3'd1, tag: 24'h111111, data: {32{8'hA1}}});
    wb_q.push_back('{idx: 3'd6, tag: 24'h666666, data: {32{8'hB6}}});
    done_snap = done_cnt;
    flush_inv_i = 1'b0; flush_req_i = 1'b1; tick();
    check("flush_busy", 256'(busy_o), 256'(1));
    wait_wb("wb1_wait");
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin
        set_wr(3'd3, 1, 24'h333333, {32{8'hC3}}, 32'hFFFFFFFF, 1, 0);
        flush_req_i = 1'b1;
      end
      tick();
      check("stall_valid", 256'(wb_valid_o), 256'(1));
      check("stall_index", 256'(wb_index_o), 256'(1));
      check("stall_tag",   256'(wb_tag_o),   256'(24'h111111));
      check("stall_data",  wb_data_o,        {32{8'hA1}});
    end
    wb_ready_i = 1'b1;
    n = 0;
    while (!flush_done_o && n < 40) begin tick(); n++; end
    check("flush1_done", 256'(flush_done_o), 256'(1));
    wb_ready_i = 1'b0;
    tick(); tick();
    check("flush1_pulses", 256'(done_cnt - done_snap), 256'(1));
    check("wb_q_drained",  256'(wb_q.size()),          256'(0));
    set_lk(3'd1, 1, 0, 24'h111111, {32{8'hA1}}); tick();
    set_lk(3'd6, 1, 0, 24'h666666, {32{8'hB6}}); tick();
    set_lk(3'd3, 0, 0, 24'h0, 256'h0); tick();

    // Clean sweep with invalidate: done exactly NSETS+1 cycles after request
    check("sweep_idle", 256'(busy_o), 256'(0));
    flush_inv_i = 1'b1; flush_req_i = 1'b1; tick();
    n = 1;
    while (!flush_done_o && n < 30) begin tick(); n++; end
    check("sweep_latency", 256'(n), 256'(9));
    tick();
    check("sweep_pulse_1cyc", 256'(flush_done_o), 256'(0));
    check("sweep_not_busy",   256'(busy_o),       256'(0));
    set_lk(3'd1, 0, 0, 24'h111111, {32{8'hA1}}); tick();
    set_lk(3'd2, 0, 0, 24'h000222, 256'h22222222_00003333); tick();
    set_lk(3'd5, 0, 0, 24'hABCDEF, 256'h11111111); tick();
    set_lk(3'd6, 0, 0, 24'h666666, {32{8'hB6}}); tick();

    // Reset while a writeback is pending
    set_wr(3'd4, 1, 24'h444444, {32{8'hC4}}, 32'hFFFFFFFF, 1, 0); tick();
    flush_inv_i = 1'b0; flush_req_i = 1'b1; tick();
    wait_wb("wb4_wait");
    check("wb4_index", 256'(wb_index_o), 256'(4));
    done_snap = done_cnt;
    rst = 1'b1; tick();
    check("abort_wbvld", 256'(wb_valid_o),   256'(0));
    check("abort_busy",  256'(busy_o),       256'(0));
    check("abort_done",  256'(flush_done_o), 256'(0));
    check("abort_valid", 256'(valid_o),      256'(0));
    rst = 1'b0;
    set_lk(3'd4, 0, 0, 24'h0, 256'h0); tick();
    set_lk(3'd2, 0, 0, 24'h0, 256'h0); tick();
    tick(); tick();
    check("abort_no_pulse", 256'(done_cnt - done_snap), 256'(0));
    check("lk_q_drained",   256'(lk_q.size()),          256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
